shift_cmd_queue: RTL and testbench

Command front-end and result collector for the 32-bit registered barrel shifter. It accepts shift commands over a valid/ready interface and buffers them in a small FIFO. It issues one command per cycle to the shifter, whose output is registered with a fixed 1-cycle latency, and captures each result into a 2-entry output buffer so downstream back-pressure never drops a result. Tags travel with each command, and results return in issue order.

---
 rtl/shift_cmd_queue_if.sv | 41 ++++
 rtl/shift_cmd_queue.sv | 138 +++++++++++++
 tb/tb_shift_cmd_queue.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_cmd_queue_if.sv
// Handshake bundle between the shift command queue and its environment:
// command channel, shifter issue/return path and result channel.
interface shift_cmd_queue_if #(
  parameter int TAG_W = 4
) ();
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_shift_left;
  logic              i_cmd_signed;
  logic [4:0]        i_cmd_amt;
  logic [31:0]       i_cmd_data;
  logic [TAG_W-1:0]  i_cmd_tag;

  logic              o_sh_shift_left;
  logic              o_sh_signed;
  logic [4:0]        o_sh_shift_amt;
  logic [31:0]       o_sh_data;
  logic [31:0]       i_sh_result;

  logic              o_res_valid;
  logic              i_res_ready;
  logic [31:0]       o_res_data;
  logic [TAG_W-1:0]  o_res_tag;
  logic              o_busy;

  // The queue itself.
  modport slave (
    input  i_cmd_valid, i_cmd_shift_left, i_cmd_signed, i_cmd_amt, i_cmd_data, i_cmd_tag,
    input  i_sh_result, i_res_ready,
    output o_cmd_ready, o_sh_shift_left, o_sh_signed, o_sh_shift_amt, o_sh_data,
    output o_res_valid, o_res_data, o_res_tag, o_busy
  );

  // Command producer, shifter and result consumer.
  modport master (
    output i_cmd_valid, i_cmd_shift_left, i_cmd_signed, i_cmd_amt, i_cmd_data, i_cmd_tag,
    output i_sh_result, i_res_ready,
    input  o_cmd_ready, o_sh_shift_left, o_sh_signed, o_sh_shift_amt, o_sh_data,
    input  o_res_valid, o_res_data, o_res_tag, o_busy
  );
endinterface

// File: rtl/shift_cmd_queue.sv
// Command FIFO in front of a registered 32-bit barrel shifter, with a 2-entry
// result buffer so back-pressure stalls issue instead of dropping results.
module shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  shift_cmd_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              shift_left;
    logic              is_signed;
    logic [4:0]        amt;
    logic [31:0]       data;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [31:0]       data;
    logic [TAG_W-1:0]  tag;
  } res_t;

  cmd_t              fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              inflight;
  logic [TAG_W-1:0]  inflight_tag;

  res_t              out_mem [2];
  logic              out_wr;
  logic              out_rd;
  logic [1:0]        out_count;

  logic  full;
  logic  empty;
  logic  cmd_ready;
  logic  push;
  logic  res_valid;
  logic  pop;
  logic  issue;
  cmd_t  cmd_in;
  cmd_t  head;
  res_t  out_head;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  // Ready is forced low while reset is held, not just after the registers clear.
  assign cmd_ready = !full && i_rst_n;
  assign push      = bus.i_cmd_valid && cmd_ready;
  assign res_valid = (out_count != 2'd0);
  assign pop       = res_valid && bus.i_res_ready;
  // In-flight plus buffered results never exceed the two buffer slots.
  assign issue     = !empty && (((out_count + {1'b0, inflight}) < 2'd2) || pop);

  assign cmd_in = '{
    shift_left: bus.i_cmd_shift_left,
    is_signed:  bus.i_cmd_signed,
    amt:        bus.i_cmd_amt,
    data:       bus.i_cmd_data,
    tag:        bus.i_cmd_tag
  };
  assign head     = fifo_mem[rd_ptr];
  assign out_head = out_mem[out_rd];

  assign bus.o_cmd_ready     = cmd_ready;
  assign bus.o_sh_shift_left = empty ? 1'b0  : head.shift_left;
  assign bus.o_sh_signed     = empty ? 1'b0  : head.is_signed;
  assign bus.o_sh_shift_amt  = empty ? 5'd0  : head.amt;
  assign bus.o_sh_data       = empty ? 32'd0 : head.data;
  assign bus.o_res_valid     = res_valid;
  assign bus.o_res_data      = res_valid ? out_head.data : 32'd0;
  assign bus.o_res_tag       = res_valid ? out_head.tag  : '0;
  assign bus.o_busy          = !empty || inflight || res_valid;

  // NOTE: storage arrays carry no reset; the counts qualify every read, and
  // leaving them unreset keeps them as plain RAM/flop arrays without reset fan-out.
  always_ff @(posedge i_clk) begin
    if (push) begin
      // NOTE: clocked state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      fifo_mem[wr_ptr] <= cmd_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, issue})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Only the tag waits for the shifter; the data comes back on i_sh_result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_tag <= head.tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (inflight) begin
      out_mem[out_wr] <= '{data: bus.i_sh_result, tag: inflight_tag};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_wr    <= 1'b0;
      out_rd    <= 1'b0;
      out_count <= 2'd0;
    end else begin
      if (inflight) out_wr <= ~out_wr;
      if (pop)      out_rd <= ~out_rd;
      case ({inflight, pop})
        2'b10:   out_count <= out_count + 2'd1;
        2'b01:   out_count <= out_count - 2'd1;
        default: out_count <= out_count;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue: models the registered shifter, the
// queue occupancy and the expected result stream.
module tb_shift_cmd_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst_n;

  shift_cmd_queue_if #(.TAG_W(TAG_W)) bus ();

  shift_cmd_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   run_len = 0;
  int   max_run = 0;
  int   m_cnt = 0;
  int   m_inf = 0;
  int   m_out = 0;
  bit   rand_en = 1'b0;
  exp_t sb [$];
  exp_t e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] shift_fn(logic l, logic s, logic [4:0] a, logic [31:0] d);
    if (l) return d << a;
    if (s) return 32'($signed(d) >>> a);
    return d >> a;
  endfunction

  // Registered shifter: samples the issue bus every cycle.
  always @(posedge i_clk)
    bus.i_sh_result <= shift_fn(bus.o_sh_shift_left, bus.o_sh_signed,
                                bus.o_sh_shift_amt, bus.o_sh_data);

  always begin
    @(posedge i_clk);
    #2;
    if (rand_en) bus.i_res_ready = 1'($urandom_range(0, 1));
  end

  // Occupancy model and result scoreboard, evaluated mid-cycle for the coming edge.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      bit pop, issue, push;
      check("cmd_ready", bus.o_cmd_ready, m_cnt != DEPTH);
      check("res_valid", bus.o_res_valid, m_out != 0);
      check("busy", bus.o_busy, (m_cnt + m_inf + m_out) != 0);
      if (bus.o_res_valid) run_len++; else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (bus.o_res_valid && bus.i_res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", bus.o_res_tag, '1);
        end else begin
          e = sb.pop_front();
          check("res_data", bus.o_res_data, e.data);
          check("res_tag", bus.o_res_tag, e.tag);
        end
      end
      pop   = (m_out != 0) && bus.i_res_ready;
      issue = (m_cnt != 0) && ((m_out + m_inf < 2) || pop);
      push  = bus.i_cmd_valid && (m_cnt != DEPTH);
      m_cnt = m_cnt + int'(push) - int'(issue);
      m_out = m_out + m_inf - int'(pop);
      m_inf = int'(issue);
    end
  end

  // Called right after a rising edge; returns just after the accepting edge.
  task automatic send(input logic l, input logic s, input logic [4:0] a,
                      input logic [31:0] d, input logic [TAG_W-1:0] t,
                      input logic [31:0] exp_data);
    int n = 0;
    bus.i_cmd_valid      = 1'b1;
    bus.i_cmd_shift_left = l;
    bus.i_cmd_signed     = s;
    bus.i_cmd_amt        = a;
    bus.i_cmd_data       = d;
    bus.i_cmd_tag        = t;
    @(negedge i_clk);
    while (!bus.o_cmd_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) begin
      check("send_timeout", 64'(n), 64'(0));
    end else begin
      sb.push_back('{exp_data, t});
      n_acc++;
    end
    @(posedge i_clk);
    #1;
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic send_model(input logic l, input logic s, input logic [4:0] a,
                            input logic [31:0] d, input logic [TAG_W-1:0] t);
    send(l, s, a, d, t, shift_fn(l, s, a, d));
  endtask

  task automatic drain();
    int n = 0;
    while (bus.o_busy && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_timeout", 64'(n < 200), 64'(1));
    check("sb_empty", 64'(sb.size()), 64'(0));
    @(posedge i_clk);
    #1;
  endtask

  task automatic latency_cmd(input logic l, input logic s, input logic [4:0] a,
                             input logic [31:0] d, input logic [TAG_W-1:0] t,
                             input logic [31:0] exp_data);
    int n = 0;
    send(l, s, a, d, t, exp_data);
    do begin
      @(negedge i_clk);
      n++;
    end while (!bus.o_res_valid && n < 10);
    check("latency", 64'(n), 64'(3));
    check("lat_data", bus.o_res_data, exp_data);
    check("lat_tag", bus.o_res_tag, t);
    drain();
  endtask

  initial begin
    int base;
    i_rst_n              = 1'b0;
    bus.i_cmd_valid      = 1'b0;
    bus.i_cmd_shift_left = 1'b0;
    bus.i_cmd_signed     = 1'b0;
    bus.i_cmd_amt        = '0;
    bus.i_cmd_data       = '0;
    bus.i_cmd_tag        = '0;
    bus.i_res_ready      = 1'b1;
    #1;
    check("rst_cmd_ready", bus.o_cmd_ready, 0);
    check("rst_res_valid", bus.o_res_valid, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_res_data", bus.o_res_data, 0);
    check("rst_res_tag", bus.o_res_tag, 0);
    check("rst_sh_data", bus.o_sh_data, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", bus.o_cmd_ready, 1);
    @(posedge i_clk);
    #1;

    // Single arithmetic right shift, latency from accept edge.
    latency_cmd(1'b0, 1'b1, 5'd4, 32'h8000_00F0, 4'd3, 32'hF800_000F);

    // Streaming: back-to-back mixed shifts with the consumer always ready.
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      logic l, s;
      l = (i % 3 == 0);
      s = (i % 3 == 2);
      send_model(l, s, 5'((i * 7) % 32), $urandom, 4'(i));
    end
    drain();
    check("stream_run", 64'(max_run), 64'(16));

    // Back-pressure: six accepts fill FIFO and output buffer.
    bus.i_res_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 6; i++)
      send_model(1'b1, 1'b0, 5'(i + 1), 32'h0000_0101 * (i + 1), 4'(i + 8));
    check("bp_accepts", 64'(n_acc - base), 64'(6));
    @(negedge i_clk);
    check("bp_ready_low", bus.o_cmd_ready, 0);
    bus.i_cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      check("bp_hold_low", bus.o_cmd_ready, 0);
    end
    @(posedge i_clk);
    #1;
    bus.i_res_ready = 1'b1;
    send_model(1'b0, 1'b0, 5'd3, 32'hF0F0_F0F0, 4'd14);
    send_model(1'b0, 1'b1, 5'd3, 32'hF0F0_F0F0, 4'd15);
    drain();

    // Boundary shift amounts.
    send(1'b1, 1'b0, 5'd31, 32'h0000_0001, 4'd1, 32'h8000_0000);
    send(1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF, 4'd2, 32'h0000_0001);
    send(1'b0, 1'b1, 5'd31, 32'h8000_0000, 4'd3, 32'hFFFF_FFFF);
    send(1'b0, 1'b1, 5'd0,  32'h8765_4321, 4'd4, 32'h8765_4321);
    send(1'b1, 1'b1, 5'd8,  32'h8000_00FF, 4'd5, 32'h0000_FF00);
    drain();

    // Asynchronous reset with FIFO and output buffer occupied.
    bus.i_res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_model(1'b0, 1'b0, 5'(i), 32'hA5A5_0000 + 32'(i), 4'(i));
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.o_res_valid, 0);
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_ready", bus.o_cmd_ready, 0);
    check("mid_rst_data", bus.o_res_data, 0);
    sb.delete();
    m_cnt = 0;
    m_inf = 0;
    m_out = 0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    #1;
    check("post_rst_ready", bus.o_cmd_ready, 1);
    bus.i_res_ready = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      check("post_rst_no_res", bus.o_res_valid, 0);
    end
    @(posedge i_clk);
    #1;
    latency_cmd(1'b1, 1'b0, 5'd4, 32'h0000_0001, 4'd5, 32'h0000_0010);

    // Pointer wrap under random consumer stalls.
    rand_en = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++)
      send_model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom, 4'(i));
    rand_en = 1'b0;
    bus.i_res_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
